// File: rtl/network_sample_scheduler_pkg.sv
// Shared constants and FSM encoding for the XADC sample scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: DRP address/data widths, VAUX base address, result width, state enum.
package nasb_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;
  localparam int RES_W      = 12;

  // VAUX0 sits at this DRP address. Channel k is read from base + k.
  localparam logic [DRP_ADDR_W-1:0] XADC_VAUX_BASE = 7'h10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/network_sample_scheduler_if.sv
// DRP read bus between the scheduler and the XADC.
// Latency: n/a (wires only).
// Backpressure: none; the XADC answers each den pulse with a later drdy pulse.
// master: drives drp_den/drp_daddr, receives drp_drdy/drp_do. slave: the reverse.
interface network_sample_scheduler_if;
  import nasb_pkg::*;

  logic                  drp_den;
  logic [DRP_ADDR_W-1:0] drp_daddr;
  logic                  drp_drdy;
  logic [DRP_DATA_W-1:0] drp_do;

  modport master (
    output drp_den,
    output drp_daddr,
    input  drp_drdy,
    input  drp_do
  );

  modport slave (
    input  drp_den,
    input  drp_daddr,
    output drp_drdy,
    output drp_do
  );

endinterface

// File: rtl/network_sample_scheduler_drp_read_timer.sv
// Down-counter that bounds how long a DRP read may wait for drdy.
// Latency: expired rises on the TIMEOUT_CYC-th enabled cycle after load.
// Backpressure: none; the counter holds at zero until it is reloaded.
// Ports: clk, rst (sync, active-high), load, en, expired.
module drp_read_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // Loading TIMEOUT_CYC-1 makes the first enabled cycle count as cycle 1,
  // so expired is seen on exactly the TIMEOUT_CYC-th enabled cycle.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/network_sample_scheduler.sv
// Scans NUM_CH XADC VAUX channels over DRP per frame, publishes results and spike flags.
// Latency: 1 + (settle_cycles+1) + sum(1 + DRP latency) + 1 cycles from start to frame_done.
// Backpressure: start is ignored while busy; a stalled DRP read is cut off after TIMEOUT_CYC cycles.
// Ports: clk/rst, start/continuous/settle_cycles/threshold control, drp bus (master),
//        ch_result/net_out results, busy/frame_done/timeout_err status, clr_err.
module network_sample_scheduler
  import nasb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SETTLE_W    = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [SETTLE_W-1:0]       settle_cycles,
  input  logic [RES_W-1:0]          threshold,
  network_sample_scheduler_if.master drp,
  output logic [RES_W*NUM_CH-1:0]   ch_result,
  output logic [NUM_CH-1:0]         net_out,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      timeout_err,
  input  logic                      clr_err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_t                  state;
  logic [SETTLE_W-1:0]     settle_cnt;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;
  logic [RES_W*NUM_CH-1:0] staging;
  logic [RES_W*NUM_CH-1:0] staging_nxt;
  logic [NUM_CH-1:0]       net_nxt;
  logic [RES_W-1:0]        slot_val;
  logic                    rd_expired;
  logic                    unused_nibble;

  // The XADC result is left-justified; the low nibble carries no data.
  assign unused_nibble = ^drp.drp_do[3:0];
  assign idx_nxt       = idx + 1'b1;
  // drdy wins over a simultaneous expiry: real data beats the error code.
  assign slot_val      = drp.drp_drdy ? drp.drp_do[15:4] : {RES_W{1'b1}};

  // Staging with the current read merged in, so the final channel can be
  // published on the same edge it is captured.
  always_comb begin
    staging_nxt = staging;
    staging_nxt[idx*RES_W +: RES_W] = slot_val;
  end

  always_comb begin
    net_nxt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      net_nxt[k] = (staging_nxt[k*RES_W +: RES_W] >= threshold);
    end
  end

  drp_read_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_drp_read_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state == S_REQ),
    .en     (state == S_WAIT),
    .expired(rd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      settle_cnt      <= '0;
      idx             <= '0;
      staging         <= '0;
      ch_result       <= '0;
      net_out         <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      timeout_err     <= 1'b0;
      drp.drp_den     <= 1'b0;
      drp.drp_daddr   <= XADC_VAUX_BASE;
    end else begin
      drp.drp_den <= 1'b0;
      frame_done  <= 1'b0;
      // A timeout later in this block overrides the clear on the same cycle.
      if (clr_err) timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SETTLE;
            settle_cnt <= settle_cycles;
            idx        <= '0;
            busy       <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state         <= S_REQ;
            drp.drp_den   <= 1'b1;
            drp.drp_daddr <= XADC_VAUX_BASE + 7'(idx);
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (drp.drp_drdy || rd_expired) begin
            staging <= staging_nxt;
            if (!drp.drp_drdy) timeout_err <= 1'b1;
            if (idx == LAST_IDX) begin
              // Outputs are loaded on entry to DONE so they become visible
              // together with the frame_done pulse, never mid-frame.
              state      <= S_DONE;
              ch_result  <= staging_nxt;
              net_out    <= net_nxt;
              frame_done <= 1'b1;
            end else begin
              state         <= S_REQ;
              idx           <= idx_nxt;
              drp.drp_den   <= 1'b1;
              drp.drp_daddr <= XADC_VAUX_BASE + 7'(idx_nxt);
            end
          end
        end
        S_DONE: begin
          if (continuous) begin
            state      <= S_SETTLE;
            settle_cnt <= settle_cycles;
            idx        <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
